// File: rtl/vm_pkg.sv
// ============================================================================
//  Module      : vm_pkg
//  Description : Shared coin-code type and constants for the vending front end.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vm_pkg;

    typedef logic [1:0] coin_t;

    localparam coin_t CN_NONE = 2'b00;
    localparam coin_t CN_A    = 2'b01;
    localparam coin_t CN_B    = 2'b10;
    localparam coin_t CN_C    = 2'b11;

endpackage

`default_nettype wire

// File: rtl/coin_db.sv
// ============================================================================
//  Module      : coin_db
//  Description : 2-flop synchronizer, saturating debounce counter and
//                single-shot coin event for one raw sensor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_db #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_evt
);

    localparam logic [7:0] c_DB_MAX  = 8'(DB_CYCLES);
    localparam logic [7:0] c_DB_LAST = 8'(DB_CYCLES - 1);

    logic       r_s1;
    logic       r_s2;
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_cnt <= 8'd0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (!r_s2) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != c_DB_MAX) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Saturation at DB_CYCLES makes this a one-shot until the input drops.
    assign o_evt = r_s2 && (r_cnt == c_DB_LAST);

endmodule

`default_nettype wire

// File: rtl/coin_conditioner.sv
// ============================================================================
//  Module      : coin_conditioner
//  Description : Debounces three coin sensors and queues accepted coins in a
//                FIFO, delivering one coin code per cycle. Optional macro
//                COIN_REJ_EN enables the REJ pulse (otherwise REJ is tied 0).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_conditioner
    import vm_pkg::*;
#(
    parameter int DB_CYCLES = 4,
    parameter int DEPTH     = 4
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  ST,
    input  logic  CA,
    input  logic  CB,
    input  logic  CC,
    output coin_t CN,
    output logic  PEND,
    output logic  REJ
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int NCH = 3;

    // Channel index 0 is highest push priority: C, then B, then A.
    localparam coin_t c_push_code [NCH] = '{CN_C, CN_B, CN_A};

    logic [NCH-1:0] w_raw;
    logic [NCH-1:0] w_evt;
    logic [NCH-1:0] w_acc;
    logic [1:0]     w_off [NCH];
    logic [1:0]     w_npush;
    logic [PW-1:0]  w_count;
    logic [PW-1:0]  w_free;
    logic           w_pop;

    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    coin_t          r_mem [DEPTH];
    coin_t          r_cn;

    assign w_raw = {CA, CB, CC};

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_chan
            coin_db #(
                .DB_CYCLES (DB_CYCLES)
            ) u_db (
                .clk   (CLK),
                .rst   (RST),
                .i_raw (w_raw[g]),
                .o_evt (w_evt[g])
            );
        end
    endgenerate

    assign w_count = r_wptr - r_rptr;
    assign w_pop   = ST && (w_count != '0);
    // Free slots are counted after this cycle's pop so a full FIFO still accepts.
    assign w_free  = PW'(DEPTH) - w_count + PW'(w_pop);

    always_comb begin
        w_acc   = '0;
        w_npush = 2'd0;
        for (int i = 0; i < NCH; i++) begin
            w_off[i] = w_npush;
            if (w_evt[i] && ST && (PW'(w_npush) < w_free)) begin
                w_acc[i] = 1'b1;
                w_npush  = w_npush + 2'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cn   <= CN_NONE;
        end else if (!ST) begin
            r_rptr <= r_wptr;
            r_cn   <= CN_NONE;
        end else begin
            r_cn   <= w_pop ? r_mem[r_rptr[AW-1:0]] : CN_NONE;
            r_rptr <= r_rptr + PW'(w_pop);
            r_wptr <= r_wptr + PW'(w_npush);
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NCH; i++) begin
            if (w_acc[i]) begin
                r_mem[r_wptr[AW-1:0] + AW'(w_off[i])] <= c_push_code[i];
            end
        end
    end

    assign CN   = r_cn;
    assign PEND = (w_count != '0);

`ifdef COIN_REJ_EN
    logic w_rej_any;
    logic r_rej;

    assign w_rej_any = |(w_evt & ~w_acc);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rej <= 1'b0;
        end else begin
            r_rej <= w_rej_any;
        end
    end

    assign REJ = r_rej;
`else
    assign REJ = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_coin_conditioner.sv
// ============================================================================
//  Module      : tb_coin_conditioner
//  Description : Randomized and directed bench for coin_conditioner against a
//                queue-based reference model (DEPTH=4 and DEPTH=2 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coin_conditioner;

    localparam int DB   = 4;
    localparam int DEP  = 4;
    localparam int DEP2 = 2;
`ifdef COIN_REJ_EN
    localparam bit REJ_ON = 1'b1;
`else
    localparam bit REJ_ON = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST, ST, CA, CB, CC;
    logic [1:0] CN, CN2;
    logic       PEND, PEND2, REJ, REJ2;

    always #5 CLK = ~CLK;

    coin_conditioner #(.DB_CYCLES(DB), .DEPTH(DEP)) u_dut (
        .CLK(CLK), .RST(RST), .ST(ST), .CA(CA), .CB(CB), .CC(CC),
        .CN(CN), .PEND(PEND), .REJ(REJ)
    );

    coin_conditioner #(.DB_CYCLES(DB), .DEPTH(DEP2)) u_dut2 (
        .CLK(CLK), .RST(RST), .ST(ST), .CA(CA), .CB(CB), .CC(CC),
        .CN(CN2), .PEND(PEND2), .REJ(REJ2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: index 0 = A, 1 = B, 2 = C; coin code = index + 1.
    bit m_d1 [3];
    bit m_d2 [3];
    int m_run [3];
    int m_q  [$];
    int m_q2 [$];
    int m_cn, m_cn2;
    bit m_rej, m_rej2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit st, input bit a, input bit b, input bit c);
        bit raw [3];
        bit ev  [3];
        raw = '{a, b, c};
        m_rej  = 1'b0;
        m_rej2 = 1'b0;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_d1[i] = 1'b0; m_d2[i] = 1'b0; m_run[i] = 0;
            end
            m_q.delete(); m_q2.delete();
            m_cn = 0; m_cn2 = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                ev[i]    = m_d2[i] && (m_run[i] + 1 == DB);
                m_run[i] = m_d2[i] ? ((m_run[i] < DB) ? m_run[i] + 1 : DB) : 0;
                m_d2[i]  = m_d1[i];
                m_d1[i]  = raw[i];
            end
            if (!st) begin
                m_q.delete(); m_q2.delete();
                m_cn = 0; m_cn2 = 0;
                m_rej  = ev[0] | ev[1] | ev[2];
                m_rej2 = m_rej;
            end else begin
                m_cn  = (m_q.size()  != 0) ? m_q.pop_front()  : 0;
                m_cn2 = (m_q2.size() != 0) ? m_q2.pop_front() : 0;
                for (int i = 2; i >= 0; i--) begin
                    if (ev[i]) begin
                        if (m_q.size() < DEP) m_q.push_back(i + 1);
                        else m_rej = 1'b1;
                        if (m_q2.size() < DEP2) m_q2.push_back(i + 1);
                        else m_rej2 = 1'b1;
                    end
                end
            end
        end
        m_rej  = m_rej  & REJ_ON;
        m_rej2 = m_rej2 & REJ_ON;
    endtask

    task automatic step(input bit rst, input bit st, input bit a, input bit b, input bit c);
        RST = rst; ST = st; CA = a; CB = b; CC = c;
        @(posedge CLK);
        model_edge(rst, st, a, b, c);
        #1;
        check("CN",    CN,    m_cn);
        check("PEND",  PEND,  (m_q.size() != 0));
        check("REJ",   REJ,   m_rej);
        check("CN_D2", CN2,   m_cn2);
        check("PEND_D2", PEND2, (m_q2.size() != 0));
        check("REJ_D2",  REJ2,  m_rej2);
    endtask

    initial begin
        int nz;
        int hold [3];
        bit val  [3];
        bit st_v;
        int st_hold;

        RST = 1'b1; ST = 1'b0; CA = 1'b0; CB = 1'b0; CC = 1'b0;
        repeat (3) step(1, 0, 0, 0, 0);
        check("RST_CN", CN, 0);
        check("RST_PEND", PEND, 0);
        repeat (4) step(0, 1, 0, 0, 0);

        // Single long coin-A press.
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 1, 0, 0);
            if (k == 6) check("A_PEND_PRE", PEND, 1);
            if (k == 7) begin
                check("A_CN", CN, 1);
                check("A_PEND_AT", PEND, 0);
            end
            if (k == 8) check("A_CN_AFTER", CN, 0);
        end
        repeat (6) step(0, 1, 0, 0, 0);

        // Coin B: short pulse, bounce, long press.
        nz = 0;
        for (int k = 1; k <= 20; k++) begin
            step(0, 1, 0, (k <= 3) || (k >= 5 && k <= 12), 0);
            if (CN == 2'b10) nz++;
        end
        check("B_ONE_EVENT", nz, 1);

        // All three coins on the same edge.
        for (int k = 1; k <= 12; k++) begin
            step(0, 1, 1, 1, 1);
            if (k == 7)  check("ABC_CN1", CN, 3);
            if (k == 8)  check("ABC_CN2", CN, 2);
            if (k == 9)  check("ABC_CN3", CN, 1);
            if (k == 10) check("ABC_CN4", CN, 0);
            if (k == 6)  check("ABC_REJ_D2", REJ2, REJ_ON);
        end
        repeat (8) step(0, 1, 0, 0, 0);

        // Coins while stopped are rejected and never delivered.
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 1, 1, 1);
            if (k == 6) check("STOP_REJ", REJ, REJ_ON);
        end
        repeat (8) step(0, 1, 0, 0, 0);

        // Reset with two coins queued and CA held high.
        for (int k = 1; k <= 7; k++) step(0, 1, 1, 1, 1);
        check("PRE_RST_PEND", PEND, 1);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        check("RST_FLUSH_PEND", PEND, 0);
        nz = 0;
        for (int k = 1; k <= 12; k++) begin
            step(0, 1, 1, 0, 0);
            if (CN != 2'b00) nz++;
            if (k == DB + 3) check("RST_A_CN", CN, 1);
        end
        check("RST_A_ONE", nz, 1);
        repeat (6) step(0, 1, 0, 0, 0);

        // Randomized bouncy inputs with occasional stop and reset.
        for (int i = 0; i < 3; i++) begin
            hold[i] = 0; val[i] = 1'b0;
        end
        st_v = 1'b1; st_hold = 30;
        repeat (3000) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    val[i]  = ~val[i];
                    hold[i] = val[i] ? int'($urandom_range(1, 9)) : int'($urandom_range(1, 6));
                end
                hold[i]--;
            end
            st_hold--;
            if (st_hold <= 0) begin
                st_v    = ~st_v;
                st_hold = st_v ? int'($urandom_range(10, 60)) : int'($urandom_range(1, 8));
            end
            step(($urandom_range(0, 299) == 0), st_v, val[0], val[1], val[2]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/coin_conditioner.md
COIN_CONDITIONER -- requirements
Module: coin_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, meaning consecutive synchronized-high samples required to accept a coin (legal 2..255).
REQ-002 SHALL have parameter DEPTH, default 4, meaning coin-event FIFO entries (power of two, 2..16).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 ST  input  1  machine started; coins accepted only while high.
REQ-006 CA  input  1  raw coin-A sensor: asynchronous, bouncy, active-high.
REQ-007 CB  input  1  raw coin-B sensor; same properties as CA.
REQ-008 CC  input  1  raw coin-C sensor; same properties as CA.
REQ-009 CN  output  2  coin code to next-state logic: 00 none, 01 A, 10 B, 11 C; non-zero exactly one cycle per accepted coin.
REQ-010 PEND  output  1  high while FIFO holds at least one undelivered coin.
REQ-011 REJ  output  1  one-cycle pulse per coin rejected (ST low or FIFO full).

Function
REQ-012 Each raw input SHALL pass a 2-flop synchronizer before any other use.
REQ-013 Per channel, a saturating counter SHALL count consecutive synchronized-high samples and reset to 0 on any low sample.
REQ-014 A coin event SHALL fire once, on the cycle the counter reaches DB_CYCLES; no further event until the synchronized input has been low at least one sample.
REQ-015 A high pulse shorter than DB_CYCLES samples SHALL produce no event, no REJ.
REQ-016 With FIFO empty and ST high, CN SHALL be non-zero in the cycle after the (DB_CYCLES+3)th rising edge counted from the first edge sampling raw input high.
REQ-017 Events firing in the same cycle SHALL be pushed in order C, B, A, as many as free entries allow; remainder rejected.
REQ-018 The FIFO SHALL pop at most one entry per cycle; CN = popped code in that cycle, 00 otherwise.
REQ-019 Push and pop in the same cycle SHALL both succeed when FIFO full; free count computed after the pop.
REQ-020 ST low SHALL flush the FIFO on the next edge, force CN = 00, and reject every event firing while low.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; occupancy tracked with an extra count bit so full and empty are distinct.
REQ-022 REJ SHALL pulse one cycle for one or more rejects in a cycle (not a count).

Reset
REQ-023 While RST high: CN = 00, PEND = 0, REJ = 0, synchronizers, counters, latched-event flags, FIFO pointers all cleared.
REQ-024 RST asserted mid-debounce or with FIFO non-empty SHALL discard all pending coins; after release a still-high input SHALL debounce from zero.

Configuration
REQ-025 Macro COIN_REJ_EN defined: REJ behaves per REQ-011/022.
REQ-026 Macro COIN_REJ_EN undefined: REJ port present, tied 0; rejected coins silently dropped; all other behaviour identical.

Structure
REQ-027 Shared package vm_pkg SHALL hold coin-code constants (CN_NONE, CN_A, CN_B, CN_C) and the 2-bit coin-code type.
REQ-028 One sub-module coin_db (synchronizer + debounce counter + single-event generator), instantiated three times.

Verification
REQ-029 DB_CYCLES=4, ST=1: CA high 10 cycles -> CN=01 for exactly one cycle after 7th edge; PEND high in the preceding cycle only; REJ never.
REQ-030 CB pulses of 3 cycles, bounce low 1, high 8 -> exactly one CN=10; no event from the 3-cycle pulse.
REQ-031 CA, CB, CC rise same edge -> CN sequence 11, 10, 01 on three consecutive cycles, then 00.
REQ-032 DEPTH=4, five events queued with pops blocked by ST toggling low/high -> ST low flushes, all events during ST low give REJ=1, CN stays 00.
REQ-033 RST pulsed two cycles while FIFO holds 2 coins and CA held high -> CN=00 during and after reset until CA debounces again (one CN=01, DB_CYCLES+3 edges after release).
REQ-034 Build without COIN_REJ_EN, repeat REQ-032 stimulus -> REJ stays 0, CN identical to REQ-032.
